// File: rtl/id_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pkg
// Purpose : Instruction-format definitions shared by fetch, decode and
//           execute: opcode constants, field bit positions, a packed view of
//           the 16-bit instruction and a small field-extraction helper.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package id_stage_pkg;

    localparam int INSTR_W = 16;

    // Field bit positions inside the 16-bit instruction word
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RI_MSB  = 11;
    localparam int RI_LSB  = 10;
    localparam int RJ_MSB  = 9;
    localparam int RJ_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes with special meaning to the decode stage
    localparam logic [3:0] OP_LOAD = 4'hE;
    localparam logic [3:0] OP_WIN  = 4'hF;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] ri;
        logic [1:0] rj;
        logic [7:0] imm;
    } instr_t;

    function automatic instr_t split_instr(input logic [INSTR_W-1:0] raw);
        instr_t f;
        f.op  = raw[OP_MSB:OP_LSB];
        f.ri  = raw[RI_MSB:RI_LSB];
        f.rj  = raw[RJ_MSB:RJ_LSB];
        f.imm = raw[IMM_MSB:IMM_LSB];
        return f;
    endfunction

endpackage

// File: rtl/id_stage_hazard.sv
// -----------------------------------------------------------------------------
// id_hazard
// Purpose : Combinational stall and operand-bypass selection for id_stage.
// Ports   : i_window            current register-window pointer
//           i_ri, i_rj          source/destination fields of the fetched instr
//           i_wb_write/dst/win  writeback request occupying read port 1
//           i_ex_valid/op/dst/win  instruction currently held for execute
//           o_stall             decode must not accept this cycle
//           o_byp_a, o_byp_b    take wb_data instead of rf_r1 / rf_r2
// -----------------------------------------------------------------------------
module id_hazard
    import id_stage_pkg::*;
(
    input  logic [1:0] i_window,
    input  logic [1:0] i_ri,
    input  logic [1:0] i_rj,
    input  logic       i_wb_write,
    input  logic [1:0] i_wb_dst,
    input  logic [1:0] i_wb_win,
    input  logic       i_ex_valid,
    input  logic [3:0] i_ex_op,
    input  logic [1:0] i_ex_dst,
    input  logic [1:0] i_ex_win,
    output logic       o_stall,
    output logic       o_byp_a,
    output logic       o_byp_b
);

    logic w_wb_same_win;
    logic w_wrong_win;
    logic w_port_busy;
    logic w_load_use;

    assign w_wb_same_win = i_wb_write && (i_wb_win == i_window);

    // A writeback steals read port 1 and the window selector. Reads are only
    // valid when the write targets the current window and the register that
    // port 1 would have read anyway (its value then comes from the bypass).
    assign w_wrong_win = i_wb_write && (i_wb_win != i_window);
    assign w_port_busy = i_wb_write && (i_wb_dst != i_ri);

    // Load data is not available until after execute, so no forwarding path.
    assign w_load_use = i_ex_valid && (i_ex_op == OP_LOAD) &&
                        (i_ex_win == i_window) &&
                        ((i_ex_dst == i_ri) || (i_ex_dst == i_rj));

    assign o_stall = w_wrong_win || w_port_busy || w_load_use;
    assign o_byp_a = w_wb_same_win && (i_wb_dst == i_ri);
    assign o_byp_b = w_wb_same_win && (i_wb_dst == i_rj);

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Purpose : Decode stage with windowed register file access. Reads operands,
//           shares register-file port 1 with writeback, bypasses writeback
//           data, detects load-use / port hazards, handles the WIN opcode
//           and presents a registered bundle to execute via valid/ready.
// Ports   : clk, rst_n                 clock, async active-low reset
//           if_valid/if_instr/if_pc    fetch side; id_ready accepts
//           r1_add, r2_add, en_wind    register-file addresses, window
//           rf_r1, rf_r2               register-file read data
//           wb_write/dst/win/data      writeback request; rf_we strobe
//           ex_valid/ex_ready          handshake to execute
//           ex_op/a/b/imm/dst/win/pc   registered decoded bundle
// -----------------------------------------------------------------------------
module id_stage
    import id_stage_pkg::*;
#(
    parameter int         PC_W      = 12,
    parameter logic [1:0] WIN_RESET = 2'b00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [15:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    output logic            id_ready,
    output logic [1:0]      r1_add,
    output logic [1:0]      r2_add,
    output logic [1:0]      en_wind,
    input  logic [15:0]     rf_r1,
    input  logic [15:0]     rf_r2,
    input  logic            wb_write,
    input  logic [1:0]      wb_dst,
    input  logic [1:0]      wb_win,
    input  logic [15:0]     wb_data,
    output logic            rf_we,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [3:0]      ex_op,
    output logic [15:0]     ex_a,
    output logic [15:0]     ex_b,
    output logic [7:0]      ex_imm,
    output logic [1:0]      ex_dst,
    output logic [1:0]      ex_win,
    output logic [PC_W-1:0] ex_pc
);

    instr_t          w_f;
    logic            w_stall;
    logic            w_byp_a;
    logic            w_byp_b;
    logic            w_accept;

    logic [1:0]      r_window;
    logic            r_ex_valid;
    logic [3:0]      r_ex_op;
    logic [15:0]     r_ex_a;
    logic [15:0]     r_ex_b;
    logic [7:0]      r_ex_imm;
    logic [1:0]      r_ex_dst;
    logic [1:0]      r_ex_win;
    logic [PC_W-1:0] r_ex_pc;

    assign w_f = split_instr(if_instr);

    id_hazard u_hazard (
        .i_window   (r_window),
        .i_ri       (w_f.ri),
        .i_rj       (w_f.rj),
        .i_wb_write (wb_write),
        .i_wb_dst   (wb_dst),
        .i_wb_win   (wb_win),
        .i_ex_valid (r_ex_valid),
        .i_ex_op    (r_ex_op),
        .i_ex_dst   (r_ex_dst),
        .i_ex_win   (r_ex_win),
        .o_stall    (w_stall),
        .o_byp_a    (w_byp_a),
        .o_byp_b    (w_byp_b)
    );

    // Single output register: accept only when it is empty or draining.
    assign id_ready = !w_stall && (!r_ex_valid || ex_ready);
    assign w_accept = if_valid && id_ready;

    // Port 1 doubles as the write port while a writeback is pending.
    assign r1_add  = wb_write ? wb_dst : w_f.ri;
    assign en_wind = wb_write ? wb_win : r_window;
    assign r2_add  = w_f.rj;
    assign rf_we   = wb_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_window   <= WIN_RESET;
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_imm   <= '0;
            r_ex_dst   <= '0;
            r_ex_win   <= '0;
            r_ex_pc    <= '0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex_op    <= w_f.op;
            r_ex_a     <= w_byp_a ? wb_data : rf_r1;
            r_ex_b     <= w_byp_b ? wb_data : rf_r2;
            r_ex_imm   <= w_f.imm;
            r_ex_dst   <= w_f.ri;
            // Window that was in effect for this instruction's reads.
            r_ex_win   <= r_window;
            r_ex_pc    <= if_pc;
            if (w_f.op == OP_WIN) begin
                r_window <= w_f.imm[1:0];
            end
        end else if (ex_ready) begin
            // Payload is left as-is; only the valid flag is dropped.
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid = r_ex_valid;
    assign ex_op    = r_ex_op;
    assign ex_a     = r_ex_a;
    assign ex_b     = r_ex_b;
    assign ex_imm   = r_ex_imm;
    assign ex_dst   = r_ex_dst;
    assign ex_win   = r_ex_win;
    assign ex_pc    = r_ex_pc;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Purpose : Directed-vector bench for id_stage with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_id_stage;

    localparam int PC_W = 12;

    logic            clk;
    logic            rst_n;
    logic            if_valid;
    logic [15:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            id_ready;
    logic [1:0]      r1_add;
    logic [1:0]      r2_add;
    logic [1:0]      en_wind;
    logic [15:0]     rf_r1;
    logic [15:0]     rf_r2;
    logic            wb_write;
    logic [1:0]      wb_dst;
    logic [1:0]      wb_win;
    logic [15:0]     wb_data;
    logic            rf_we;
    logic            ex_valid;
    logic            ex_ready;
    logic [3:0]      ex_op;
    logic [15:0]     ex_a;
    logic [15:0]     ex_b;
    logic [7:0]      ex_imm;
    logic [1:0]      ex_dst;
    logic [1:0]      ex_win;
    logic [PC_W-1:0] ex_pc;

    int n_vec;
    int n_bad;

    id_stage #(.PC_W(PC_W), .WIN_RESET(2'b00)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .id_ready (id_ready),
        .r1_add   (r1_add),
        .r2_add   (r2_add),
        .en_wind  (en_wind),
        .rf_r1    (rf_r1),
        .rf_r2    (rf_r2),
        .wb_write (wb_write),
        .wb_dst   (wb_dst),
        .wb_win   (wb_win),
        .wb_data  (wb_data),
        .rf_we    (rf_we),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_op    (ex_op),
        .ex_a     (ex_a),
        .ex_b     (ex_b),
        .ex_imm   (ex_imm),
        .ex_dst   (ex_dst),
        .ex_win   (ex_win),
        .ex_pc    (ex_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        rf_r1    = 16'hAAAA;
        rf_r2    = 16'h5555;
        wb_write = 1'b0;
        wb_dst   = '0;
        wb_win   = '0;
        wb_data  = '0;
        ex_ready = 1'b1;
        #12;

        // ---- reset state
        chk("rst ex_valid", ex_valid, 0);
        chk("rst ex_a", ex_a, 0);
        chk("rst ex_pc", ex_pc, 0);
        chk("rst en_wind", en_wind, 0);
        chk("rst id_ready", id_ready, 1);

        // ---- WIN F203: ri=0 rj=2 imm=03 -> window becomes imm[1:0]=3
        rst_n    = 1'b1;
        if_valid = 1'b1;
        if_instr = 16'hF203;
        if_pc    = 12'h100;
        #1;
        chk("win id_ready", id_ready, 1);
        tick();
        if_valid = 1'b0;
        chk("win ex_valid", ex_valid, 1);
        chk("win ex_op", ex_op, 4'hF);
        chk("win ex_win", ex_win, 0);
        chk("win ex_dst", ex_dst, 0);
        chk("win ex_imm", ex_imm, 8'h03);
        chk("win ex_pc", ex_pc, 12'h100);
        chk("win ex_a", ex_a, 16'hAAAA);
        chk("win en_wind", en_wind, 3);
        tick();
        chk("drain ex_valid", ex_valid, 0);

        // ---- WIN F200 back to window 0; ex_win shows the pre-update window 3
        if_valid = 1'b1;
        if_instr = 16'hF200;
        tick();
        if_valid = 1'b0;
        chk("win0 en_wind", en_wind, 0);
        chk("win0 ex_win", ex_win, 3);

        // ---- writeback bypass to operand A: ri=1, wb_dst=1, same window
        wb_write = 1'b1;
        wb_dst   = 2'd1;
        wb_win   = 2'd0;
        wb_data  = 16'h1234;
        if_valid = 1'b1;
        if_instr = 16'h1400;
        if_pc    = 12'h101;
        #1;
        chk("bypa id_ready", id_ready, 1);
        chk("bypa r1_add", r1_add, 1);
        chk("bypa en_wind", en_wind, 0);
        chk("bypa rf_we", rf_we, 1);
        tick();
        chk("bypa ex_a", ex_a, 16'h1234);
        chk("bypa ex_b", ex_b, 16'h5555);
        chk("bypa ex_dst", ex_dst, 1);

        // ---- bypass both operands: ri=rj=1
        wb_data  = 16'hBEEF;
        if_instr = 16'h2500;
        #1;
        chk("bypab id_ready", id_ready, 1);
        tick();
        chk("bypab ex_a", ex_a, 16'hBEEF);
        chk("bypab ex_b", ex_b, 16'hBEEF);

        // ---- port busy: write to r2 while instruction reads ri=1
        wb_dst   = 2'd2;
        if_instr = 16'h1400;
        #1;
        chk("busy id_ready", id_ready, 0);
        chk("busy r1_add", r1_add, 2);

        // ---- writeback into another window stalls decode
        wb_dst   = 2'd0;
        wb_win   = 2'd3;
        if_instr = 16'h3600;
        if_pc    = 12'h102;
        #1;
        chk("wwin id_ready", id_ready, 0);
        chk("wwin en_wind", en_wind, 3);
        chk("wwin rf_we", rf_we, 1);
        tick();
        chk("wwin ex_valid", ex_valid, 0);
        wb_write = 1'b0;
        #1;
        chk("wwin2 id_ready", id_ready, 1);
        chk("wwin2 r1_add", r1_add, 1);
        chk("wwin2 r2_add", r2_add, 2);
        chk("wwin2 en_wind", en_wind, 0);
        tick();
        chk("wwin2 ex_valid", ex_valid, 1);
        chk("wwin2 ex_op", ex_op, 3);
        chk("wwin2 ex_pc", ex_pc, 12'h102);
        chk("wwin2 ex_a", ex_a, 16'hAAAA);

        // ---- load-use: LOAD ri=2, then instruction with rj=2
        if_instr = 16'hE800;
        if_pc    = 12'h103;
        tick();
        chk("ld ex_op", ex_op, 4'hE);
        chk("ld ex_dst", ex_dst, 2);
        chk("ld ex_win", ex_win, 0);
        if_instr = 16'h1200;
        if_pc    = 12'h104;
        #1;
        chk("lu id_ready", id_ready, 0);
        tick();
        chk("lu ex_valid", ex_valid, 0);
        chk("lu2 id_ready", id_ready, 1);
        tick();
        chk("lu2 ex_valid", ex_valid, 1);
        chk("lu2 ex_op", ex_op, 1);
        chk("lu2 ex_pc", ex_pc, 12'h104);

        // ---- backpressure: EX holds for 3 cycles
        ex_ready = 1'b0;
        if_instr = 16'h4C00;
        if_pc    = 12'h123;
        #1;
        chk("bp id_ready", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp ex_valid", ex_valid, 1);
            chk("bp ex_op", ex_op, 1);
            chk("bp ex_pc", ex_pc, 12'h104);
            chk("bp id_ready", id_ready, 0);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp rel id_ready", id_ready, 1);
        tick();
        chk("bp rel ex_op", ex_op, 4);
        chk("bp rel ex_dst", ex_dst, 3);
        chk("bp rel ex_pc", ex_pc, 12'h123);

        // ---- async reset while holding a WIN instruction
        if_instr = 16'hF201;
        if_pc    = 12'h124;
        tick();
        if_valid = 1'b0;
        ex_ready = 1'b0;
        #1;
        chk("ar pre en_wind", en_wind, 1);
        chk("ar pre ex_valid", ex_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar ex_valid", ex_valid, 0);
        chk("ar ex_op", ex_op, 0);
        chk("ar ex_pc", ex_pc, 0);
        chk("ar en_wind", en_wind, 0);
        #2;
        rst_n    = 1'b1;
        if_valid = 1'b1;
        if_instr = 16'h5000;
        if_pc    = 12'h125;
        ex_ready = 1'b1;
        #1;
        chk("ar2 id_ready", id_ready, 1);
        tick();
        chk("ar2 ex_valid", ex_valid, 1);
        chk("ar2 ex_op", ex_op, 5);
        chk("ar2 ex_win", ex_win, 0);
        chk("ar2 ex_pc", ex_pc, 12'h125);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
